// File: rtl/serial_reg_bridge.sv
// Serial-to-register bridge: shifts words in and out over a bit strobe and
// commits each received word into a slot of a parallel register bank.
module serial_reg_bridge #(
    parameter int WIDTH     = 32,
    parameter int NREGS     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                       clk_sys,
    input  logic                       sys_reset,
    input  logic                       frame_start,
    input  logic                       bit_en,
    input  logic                       bit_in,
    input  logic                       sync_en,
    input  logic [NREGS*WIDTH-1:0]     par_in,
    output logic                       bit_out,
    output logic [NREGS*WIDTH-1:0]     par_out,
    output logic [NREGS-1:0]           par_out_valid,
    output logic [$clog2(NREGS)-1:0]   slot,
    output logic                       align_err
);

    localparam int SW = $clog2(NREGS);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] snap_q [NREGS];
    logic [WIDTH-1:0] snap_d [NREGS];
    logic [WIDTH-1:0] par_q  [NREGS];
    logic [WIDTH-1:0] par_d  [NREGS];
    logic [WIDTH-1:0] in_q, in_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    slot_q, slot_d, slot_nxt;
    logic [NREGS-1:0] valid_q, valid_d;
    logic             err_q, err_d;

    assign slot_nxt = (slot_q == SW'(NREGS - 1)) ? '0 : slot_q + SW'(1);

    // Priority: frame_start > sync_en > bit_en; losers in the same cycle are dropped.
    always_comb begin
        snap_d  = snap_q;
        par_d   = par_q;
        in_d    = in_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        valid_d = '0;
        err_d   = err_q;
        if (frame_start) begin
            for (int k = 0; k < NREGS; k++) begin
                snap_d[k] = par_in[k*WIDTH +: WIDTH];
            end
            slot_d = '0;
            cnt_d  = '0;
            in_d   = '0;
            out_d  = par_in[WIDTH-1:0];
            err_d  = 1'b0;
        end else if (sync_en) begin
            if (cnt_q == '0) begin
                par_d[slot_q]   = in_q;
                valid_d[slot_q] = 1'b1;
                slot_d          = slot_nxt;
                out_d           = snap_q[slot_nxt];
                in_d            = '0;
            end else begin
                err_d = 1'b1;
                cnt_d = '0;
            end
        end else if (bit_en) begin
            if (LSB_FIRST != 0) begin
                in_d  = {bit_in, in_q[WIDTH-1:1]};
                out_d = out_q >> 1;
            end else begin
                in_d  = {in_q[WIDTH-2:0], bit_in};
                out_d = out_q << 1;
            end
            cnt_d = (cnt_q == CW'(WIDTH - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (sys_reset) begin
            for (int k = 0; k < NREGS; k++) begin
                snap_q[k] <= '0;
                par_q[k]  <= '0;
            end
            in_q    <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            snap_q  <= snap_d;
            par_q   <= par_d;
            in_q    <= in_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_pack
        assign par_out[g*WIDTH +: WIDTH] = par_q[g];
    end

    assign bit_out       = (LSB_FIRST != 0) ? out_q[0] : out_q[WIDTH-1];
    assign par_out_valid = valid_q;
    assign slot          = slot_q;
    assign align_err     = err_q;

endmodule

// File: tb/tb_serial_reg_bridge.sv
// Directed bench for serial_reg_bridge: default LSB-first instance plus an
// 8-bit MSB-first instance, with queued expected bits and commits.
module tb_serial_reg_bridge;

    logic         clk_sys = 1'b0;
    logic         sys_reset = 1'b1;

    logic         frame_a = 0, bit_en_a = 0, bit_in_a = 0, sync_a = 0;
    logic [127:0] par_in_a = '0;
    logic         bit_out_a;
    logic [127:0] par_out_a;
    logic [3:0]   valid_a;
    logic [1:0]   slot_a;
    logic         err_a;

    logic         frame_b = 0, bit_en_b = 0, bit_in_b = 0, sync_b = 0;
    logic [15:0]  par_in_b = '0;
    logic         bit_out_b;
    logic [15:0]  par_out_b;
    logic [1:0]   valid_b;
    logic [0:0]   slot_b;
    logic         err_b;

    serial_reg_bridge dut_a (
        .clk_sys(clk_sys), .sys_reset(sys_reset), .frame_start(frame_a),
        .bit_en(bit_en_a), .bit_in(bit_in_a), .sync_en(sync_a), .par_in(par_in_a),
        .bit_out(bit_out_a), .par_out(par_out_a), .par_out_valid(valid_a),
        .slot(slot_a), .align_err(err_a)
    );

    serial_reg_bridge #(.WIDTH(8), .NREGS(2), .LSB_FIRST(0)) dut_b (
        .clk_sys(clk_sys), .sys_reset(sys_reset), .frame_start(frame_b),
        .bit_en(bit_en_b), .bit_in(bit_in_b), .sync_en(sync_b), .par_in(par_in_b),
        .bit_out(bit_out_b), .par_out(par_out_b), .par_out_valid(valid_b),
        .slot(slot_b), .align_err(err_b)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct { logic [1:0] s; logic [31:0] d; } commit_t;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [31:0] m_snap [4];
    logic [31:0] m_par  [4];
    logic [31:0] m_rx;
    logic [1:0]  m_slot;
    logic [4:0]  m_cnt;
    logic        m_err;
    logic        txq [$];
    commit_t     cq  [$];
    commit_t     e;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [127:0] packp();
        logic [127:0] p;
        for (int k = 0; k < 4; k++) p[k*32 +: 32] = m_par[k];
        return p;
    endfunction

    task automatic load_tx(input logic [31:0] w);
        txq.delete();
        for (int i = 0; i < 32; i++) txq.push_back(w[i]);
    endtask

    task automatic model_frame(input logic [127:0] pin);
        for (int k = 0; k < 4; k++) m_snap[k] = pin[k*32 +: 32];
        m_slot = '0;
        m_cnt  = '0;
        m_rx   = '0;
        m_err  = 1'b0;
        load_tx(m_snap[0]);
    endtask

    task automatic a_frame(input logic [127:0] pin);
        par_in_a = pin;
        frame_a  = 1;
        step();
        frame_a  = 0;
        model_frame(pin);
        chk("a_frame_slot", 128'(slot_a), 128'(m_slot));
        chk("a_frame_err", 128'(err_a), 128'(0));
        chk("a_frame_valid", 128'(valid_a), 128'(0));
    endtask

    task automatic a_bit(input logic b);
        logic x;
        x = (txq.size() > 0) ? txq.pop_front() : 1'b0;
        chk("a_tx_bit", 128'(bit_out_a), 128'(x));
        bit_en_a = 1;
        bit_in_a = b;
        step();
        bit_en_a = 0;
        m_rx  = {b, m_rx[31:1]};
        m_cnt = m_cnt + 5'd1;
    endtask

    task automatic a_word(input logic [31:0] w);
        for (int i = 0; i < 32; i++) a_bit(w[i]);
    endtask

    task automatic a_sync();
        logic [1:0] nxt;
        sync_a = 1;
        step();
        sync_a = 0;
        if (m_cnt == 5'd0) begin
            m_par[m_slot] = m_rx;
            cq.push_back('{s: m_slot, d: m_rx});
            nxt    = m_slot + 2'd1;
            load_tx(m_snap[nxt]);
            m_slot = nxt;
            m_rx   = '0;
        end else begin
            m_err = 1'b1;
            m_cnt = '0;
        end
        if (cq.size() > 0) begin
            e = cq.pop_front();
            chk("a_commit_valid", 128'(valid_a), 128'(4'(1) << e.s));
            chk("a_commit_data", 128'(par_out_a[e.s*32 +: 32]), 128'(e.d));
        end else begin
            chk("a_nocommit_valid", 128'(valid_a), 128'(0));
        end
        chk("a_par_out", par_out_a, packp());
        chk("a_slot", 128'(slot_a), 128'(m_slot));
        chk("a_align_err", 128'(err_a), 128'(m_err));
        step();
        chk("a_valid_oneshot", 128'(valid_a), 128'(0));
    endtask

    logic [127:0] frame0;
    logic         txb [8];
    logic [7:0]   rxv;

    initial begin
        for (int k = 0; k < 4; k++) m_par[k] = '0;
        m_rx = '0; m_slot = '0; m_cnt = '0; m_err = 1'b0;

        step();
        step();
        sys_reset = 0;
        chk("rst_bit_out", 128'(bit_out_a), 128'(0));
        chk("rst_par_out", par_out_a, 128'(0));
        chk("rst_valid", 128'(valid_a), 128'(0));
        chk("rst_slot", 128'(slot_a), 128'(0));
        chk("rst_err", 128'(err_a), 128'(0));

        // Basic word, then remaining slots with par_in scrambled mid-frame.
        frame0 = {32'h0F1E_2D3C, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'hA5A5_0F0F};
        a_frame(frame0);
        a_word(32'h1234_5678);
        a_sync();
        par_in_a = {4{32'h5555_AAAA}};
        a_word(32'h1111_2222);
        a_sync();
        a_word(32'h3333_4444);
        a_sync();
        a_word(32'h5555_6666);
        a_sync();
        chk("wrap_slot0", 128'(slot_a), 128'(0));
        a_word(32'h7777_8888);
        a_sync();

        // Misaligned commit, cleared by frame_start.
        for (int i = 0; i < 5; i++) a_bit(1'b1);
        a_sync();
        chk("err_sticky", 128'(err_a), 128'(1));
        a_frame(frame0);
        chk("err_cleared", 128'(err_a), 128'(0));

        // frame_start wins over sync_en and bit_en in the same cycle.
        a_word(32'h9ABC_DEF0);
        a_sync();
        frame_a = 1; sync_a = 1; bit_en_a = 1; bit_in_a = 1;
        step();
        frame_a = 0; sync_a = 0; bit_en_a = 0; bit_in_a = 0;
        model_frame(par_in_a);
        chk("prio_slot", 128'(slot_a), 128'(0));
        chk("prio_valid", 128'(valid_a), 128'(0));
        chk("prio_par_out", par_out_a, packp());
        a_word(32'h0BAD_CAFE);
        a_sync();

        // MSB-first 8-bit instance.
        txb = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        rxv = 8'h81;
        par_in_b = {8'h5A, 8'hC3};
        frame_b = 1;
        step();
        frame_b = 0;
        for (int i = 0; i < 8; i++) begin
            chk("b_tx_bit", 128'(bit_out_b), 128'(txb[i]));
            bit_en_b = 1;
            bit_in_b = rxv[7-i];
            step();
            bit_en_b = 0;
        end
        sync_b = 1;
        step();
        sync_b = 0;
        chk("b_commit_data", 128'(par_out_b[7:0]), 128'(8'h81));
        chk("b_commit_valid", 128'(valid_b), 128'(2'b01));
        chk("b_slot", 128'(slot_b), 128'(1));
        chk("b_next_word_bit", 128'(bit_out_b), 128'(0));

        // Reset mid-word discards and does not commit.
        for (int i = 0; i < 10; i++) a_bit(1'b1);
        sys_reset = 1;
        step();
        sys_reset = 0;
        txq.delete();
        chk("midrst_bit_out", 128'(bit_out_a), 128'(0));
        chk("midrst_par_out", par_out_a, 128'(0));
        chk("midrst_valid", 128'(valid_a), 128'(0));
        chk("midrst_slot", 128'(slot_a), 128'(0));
        chk("midrst_err", 128'(err_a), 128'(0));
        chk("midrst_b_par_out", 128'(par_out_b), 128'(0));
        step();
        chk("midrst_valid_after", 128'(valid_a), 128'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
